// File: rtl/led_pkg.sv
// Shared types and mode encodings for the multi-channel LED blink core.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_BURST = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_ON     = 2'd1,
        S_PH_ON  = 2'd2,
        S_PH_OFF = 2'd3
    } led_state_t;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

endpackage

// File: rtl/led_multi_controller_channel.sv
// One LED channel: mode FSM, half-period counter and burst pulse counter.
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned N       = 27,
    parameter int unsigned BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       period,
    input  logic [BURST_W-1:0] burst,
    input  logic               sync,
    output logic               led_o,
    output logic               busy_o
);

    led_state_t         r_state;
    led_mode_t          r_mode;
    logic [N-1:0]       r_period;
    logic [N-1:0]       r_cnt;
    logic [BURST_W-1:0] r_left;
    logic               r_led;
    logic               r_busy;

    led_state_t         w_state_nx;
    led_mode_t          w_mode_nx;
    logic [N-1:0]       w_period_nx;
    logic [N-1:0]       w_cnt_nx;
    logic [BURST_W-1:0] w_left_nx;
    logic               w_led_nx;
    logic               w_busy_nx;
    logic               w_phase_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_OFF;
            r_mode   <= LED_OFF;
            r_period <= '0;
            r_cnt    <= '0;
            r_left   <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_mode   <= w_mode_nx;
            r_period <= w_period_nx;
            r_cnt    <= w_cnt_nx;
            r_left   <= w_left_nx;
            r_led    <= w_led_nx;
            r_busy   <= w_busy_nx;
        end
    end

    // Priority: write, then sync (BLINK only), then phase timing.
    always_comb begin
        w_state_nx  = r_state;
        w_mode_nx   = r_mode;
        w_period_nx = r_period;
        w_cnt_nx    = r_cnt;
        w_left_nx   = r_left;
        w_phase_end = (r_cnt == r_period);

        if (wr) begin
            w_mode_nx   = led_mode_t'(mode);
            w_period_nx = period;
            w_cnt_nx    = '0;
            w_left_nx   = '0;
            case (mode)
                MODE_OFF:   w_state_nx = S_OFF;
                MODE_ON:    w_state_nx = S_ON;
                MODE_BLINK: w_state_nx = S_PH_ON;
                default: begin
                    if (burst != '0) begin
                        w_state_nx = S_PH_ON;
                        w_left_nx  = burst;
                    end else begin
                        w_state_nx = S_OFF;
                    end
                end
            endcase
        end else if (sync && (r_mode == LED_BLINK)) begin
            w_state_nx = S_PH_ON;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                S_PH_ON: begin
                    if (w_phase_end) begin
                        w_cnt_nx = '0;
                        if (r_mode == LED_BURST) begin
                            w_left_nx  = r_left - BURST_W'(1);
                            w_state_nx = (r_left == BURST_W'(1)) ? S_OFF : S_PH_OFF;
                        end else begin
                            w_state_nx = S_PH_OFF;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + N'(1);
                    end
                end
                S_PH_OFF: begin
                    if (w_phase_end) begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_PH_ON;
                    end else begin
                        w_cnt_nx = r_cnt + N'(1);
                    end
                end
                default: ;
            endcase
        end

        w_led_nx  = (w_state_nx == S_ON) || (w_state_nx == S_PH_ON);
        w_busy_nx = (w_left_nx != '0);
    end

    assign led_o  = r_led;
    assign busy_o = r_busy;

endmodule

// File: rtl/led_multi_controller.sv
// Multi-channel LED blink core: decodes the config address and fans out to channels.
module led_multi_controller
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned N        = 27,
    parameter int unsigned BURST_W  = 4,
    parameter int unsigned ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wr,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [1:0]          cfg_mode,
    input  logic [N-1:0]        cfg_period,
    input  logic [BURST_W-1:0]  cfg_burst,
    input  logic                sync_all,
    output logic [NUM_LEDS-1:0] led,
    output logic [NUM_LEDS-1:0] busy
);

    logic [NUM_LEDS-1:0] w_wr;

    // Out-of-range addresses match no channel, so the write is dropped.
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        assign w_wr[gi] = cfg_wr && (cfg_addr == ADDR_W'(gi));

        led_channel #(
            .N       (N),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .wr     (w_wr[gi]),
            .mode   (cfg_mode),
            .period (cfg_period),
            .burst  (cfg_burst),
            .sync   (sync_all),
            .led_o  (led[gi]),
            .busy_o (busy[gi])
        );
    end

endmodule

// File: tb/tb_led_multi_controller.sv
// Scoreboard bench for led_multi_controller using an elapsed-time pattern model.
module tb_led_multi_controller;

    localparam int unsigned NL = 4;
    localparam int unsigned NW = 27;
    localparam int unsigned BW = 4;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_wr;
    logic [AW-1:0] cfg_addr;
    logic [1:0]    cfg_mode;
    logic [NW-1:0] cfg_period;
    logic [BW-1:0] cfg_burst;
    logic          sync_all;
    logic [NL-1:0] led;
    logic [NL-1:0] busy;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    logic [7:0] sb_q[$];

    int     m_mode [NL];
    int     m_p    [NL];
    int     m_b    [NL];
    longint m_t    [NL];

    always #5 clk = ~clk;

    led_multi_controller #(
        .NUM_LEDS (NL),
        .N        (NW),
        .BURST_W  (BW),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_burst  (cfg_burst),
        .sync_all   (sync_all),
        .led        (led),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_n, got, exp);
        end
    endtask

    // Expected {busy, led} derived from cycles elapsed since the last write/sync.
    function automatic logic [7:0] model_out();
        logic [3:0] l;
        logic [3:0] b;
        longint     ph;
        l = '0;
        b = '0;
        for (int i = 0; i < NL; i++) begin
            ph = m_t[i] / longint'(m_p[i] + 1);
            case (m_mode[i])
                1: l[i] = 1'b1;
                2: l[i] = (ph % 2 == 0);
                3: if (m_b[i] > 0 && ph < longint'(2 * m_b[i] - 1)) begin
                       b[i] = 1'b1;
                       l[i] = (ph % 2 == 0);
                   end
                default: ;
            endcase
        end
        return {b, l};
    endfunction

    task automatic cyc(input logic wr, input int addr, input int mode, input int p,
                       input int bu, input logic sy, input logic rs);
        logic [7:0] e;
        rst        = rs;
        cfg_wr     = wr;
        cfg_addr   = AW'(addr);
        cfg_mode   = 2'(mode);
        cfg_period = NW'(p);
        cfg_burst  = BW'(bu);
        sync_all   = sy;
        for (int i = 0; i < NL; i++) begin
            if (rs) begin
                m_mode[i] = 0; m_p[i] = 0; m_b[i] = 0; m_t[i] = 0;
            end else if (wr && addr == i) begin
                m_mode[i] = mode; m_p[i] = p; m_b[i] = bu; m_t[i] = 0;
            end else if (sy && m_mode[i] == 2) begin
                m_t[i] = 0;
            end else begin
                m_t[i] = m_t[i] + 1;
            end
        end
        e = model_out();
        @(posedge clk);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wr_ch(input int addr, input int mode, input int p, input int bu);
        cyc(1'b1, addr, mode, p, bu, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            cyc_n++;
            chk("led",  {4'b0, led},  {4'b0, e[3:0]});
            chk("busy", {4'b0, busy}, {4'b0, e[7:4]});
        end
    end

    initial begin
        for (int i = 0; i < NL; i++) begin
            m_mode[i] = 0; m_p[i] = 0; m_b[i] = 0; m_t[i] = 0;
        end
        // Reset, then quiet hold.
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        idle(100);

        // Blink channels, slow and every-cycle.
        wr_ch(0, 2, 3, 0);
        wr_ch(1, 2, 0, 0);
        idle(20);

        // Counted burst, then idle forever.
        wr_ch(2, 3, 1, 3);
        idle(15);
        wr_ch(2, 3, 4, 0);
        idle(3);

        // Solid on for two cycles, then an out-of-range write.
        wr_ch(3, 1, 0, 0);
        idle(1);
        wr_ch(3, 0, 0, 0);
        wr_ch(5, 1, 0, 0);
        idle(4);

        // Phase alignment with a burst in flight.
        wr_ch(0, 2, 7, 0);
        idle(5);
        wr_ch(1, 2, 7, 0);
        wr_ch(2, 3, 2, 4);
        idle(6);
        cyc(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        idle(30);

        // Reset mid-burst, then write and sync colliding.
        wr_ch(2, 3, 1, 3);
        idle(3);
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        idle(3);
        wr_ch(1, 2, 2, 0);
        idle(4);
        cyc(1'b1, 0, 1, 0, 0, 1'b1, 1'b0);
        idle(12);

        @(negedge clk);
        #1;
        chk("sb_drain", 8'(sb_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
